seven_seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seven_seg_scan_driver.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Time-multiplexed driver for an N-digit common-anode 7-segment display.
//   A shadow register captures new digit words at any time. The visible
//   display word is refreshed from the shadow only when the scan wraps back
//   to digit 0, so a frame never mixes old and new digits. Each digit slot
//   starts with a short dead time with all anodes off, which suppresses
//   ghosting while the segment lines change.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset, synchronous release
//   digits_in   nibble k = digit k, digit 0 is the rightmost (LSD)
//   load        capture digits_in into the shadow register this cycle
//   hex_mode    1: nibbles 10-15 render as A b C d E F; 0: they render blank
//   blank_lz    1: suppress leading zeros (digit 0 always shown)
//   seg         {A,B,C,D,E,F,G}, active-low
//   an          digit enables, active-low, at most one bit low
//   pending     shadow holds data not yet on the display
//   frame_done  one-cycle pulse in the cycle after the scan wraps to digit 0
//
// load is a fire-and-forget strobe: there is no ready, every load is
// accepted, and the most recent one before a wrap is what gets displayed.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int DEAD_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]         DEAD      = PW'(DEAD_CYC);
  localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
  localparam logic [6:0]            SEG_OFF   = 7'b1111111;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_shadow;
  logic [DW-1:0]         r_display;
  logic                  r_pending;
  logic                  r_frame_done;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_presc_end;
  logic                  w_wrap;
  logic [PW-1:0]         w_presc_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [DW-1:0]         w_disp_nxt;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    if (!hex && v > 4'd9) g = SEG_OFF;
    return g;
  endfunction

  // Scan position after the coming edge.
  always_comb begin
    w_presc_end = (r_presc == PRESC_MAX);
    w_wrap      = w_presc_end && (r_idx == IDX_MAX);
    w_presc_nxt = w_presc_end ? '0 : r_presc + 1'b1;
    w_idx_nxt   = r_idx;
    if (w_presc_end) w_idx_nxt = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    // The commit uses the shadow as it stood before this edge.
    w_disp_nxt  = (w_wrap && r_pending) ? r_shadow : r_display;
  end

  // Outputs are computed for the post-edge scan position and display word so
  // the registered pins line up with prescaler/scan_idx.
  always_comb begin : b_out
    logic       l_all_zero;
    logic       l_blank;
    logic [3:0] l_nib;
    w_seg_nxt  = SEG_OFF;
    w_an_nxt   = '1;
    l_all_zero = 1'b1;
    l_blank    = 1'b0;
    l_nib      = '0;
    // Walk from the MSD down: a digit is a leading zero while it and every
    // digit above it is zero. Decimal 10-15 count as non-zero here.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      l_all_zero = l_all_zero & (w_disp_nxt[4*k +: 4] == 4'd0);
      if (IW'(k) == w_idx_nxt) begin
        l_nib   = w_disp_nxt[4*k +: 4];
        l_blank = blank_lz && (k != 0) && l_all_zero;
      end
    end
    if (w_presc_nxt >= DEAD) begin
      w_an_nxt  = ~(AN_ONE << w_idx_nxt);
      w_seg_nxt = l_blank ? SEG_OFF : glyph(l_nib, hex_mode);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_display    <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_OFF;
      r_an         <= '1;
    end else begin
      r_presc      <= w_presc_nxt;
      r_idx        <= w_idx_nxt;
      r_display    <= w_disp_nxt;
      r_frame_done <= w_wrap;
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      if (load) r_shadow <= digits_in;
      // A load on the wrap edge keeps pending set for the freshly captured word.
      r_pending    <= load | (r_pending & ~w_wrap);
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = N * DIV;

  // Glyph table indexed by nibble value (A..F used only in hex mode).
  localparam logic [6:0] GLYPH_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic          clk;
  logic          reset_n;
  logic [4*N-1:0] digits_in;
  logic          load;
  logic          hex_mode;
  logic          blank_lz;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic          pending;
  logic          frame_done;

  // Reference model state: cycles since reset release plus the two words.
  int            t;
  logic [15:0]   m_shadow;
  logic [15:0]   m_disp;
  logic          m_pend;
  logic          m_fd;

  int            n_vec;
  int            n_err;

  seven_seg_scan_driver #(
    .NUM_DIGITS(N),
    .CLK_DIV   (DIV),
    .DEAD_CYC  (DEAD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .digits_in (digits_in),
    .load      (load),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .pending   (pending),
    .frame_done(frame_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [6:0] ref_glyph(input int v, input logic hx);
    if (!hx && v > 9) return 7'b1111111;
    return GLYPH_TAB[v];
  endfunction

  task automatic model_reset();
    t        = 0;
    m_shadow = 16'h0;
    m_disp   = 16'h0;
    m_pend   = 1'b0;
    m_fd     = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input logic ld, input logic [15:0] din);
    logic wrap;
    t    = t + 1;
    wrap = (t % FRAME) == 0;
    if (wrap && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_shadow = din;
      m_pend   = 1'b1;
    end
    m_fd = wrap;
  endtask

  task automatic check_outputs(input string tag);
    int         presc;
    int         idx;
    int         upper;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    presc = t % DIV;
    idx   = (t / DIV) % N;
    upper = int'(m_disp) >> (4 * idx);
    if (presc < DEAD) begin
      e_seg = 7'b1111111;
      e_an  = 4'b1111;
    end else begin
      e_an = ~(4'b0001 << idx);
      if (blank_lz && idx > 0 && upper == 0) e_seg = 7'b1111111;
      else e_seg = ref_glyph(upper % 16, hex_mode);
    end
    n_vec++;
    assert (seg === e_seg) else begin
      n_err++;
      $error("FAIL %s seg t=%0d got %b exp %b", tag, t, seg, e_seg);
    end
    n_vec++;
    assert (an === e_an) else begin
      n_err++;
      $error("FAIL %s an t=%0d got %b exp %b", tag, t, an, e_an);
    end
    n_vec++;
    assert (pending === m_pend) else begin
      n_err++;
      $error("FAIL %s pending t=%0d got %b exp %b", tag, t, pending, m_pend);
    end
    n_vec++;
    assert (frame_done === m_fd) else begin
      n_err++;
      $error("FAIL %s frame_done t=%0d got %b exp %b", tag, t, frame_done, m_fd);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input logic ld, input logic [15:0] din);
    load      = ld;
    digits_in = din;
    @(posedge clk);
    model_edge(ld, din);
    #1;
    check_outputs(tag);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0);
  endtask

  // Advance until the model's frame phase equals ph (bounded by one frame).
  task automatic run_to_phase(input string tag, input int ph);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) step(tag, 1'b0, 16'h0);
  endtask

  task automatic check_reset_state(input string tag);
    n_vec++;
    assert (seg === 7'b1111111) else begin
      n_err++;
      $error("FAIL %s seg got %b exp 1111111", tag, seg);
    end
    n_vec++;
    assert (an === 4'b1111) else begin
      n_err++;
      $error("FAIL %s an got %b exp 1111", tag, an);
    end
    n_vec++;
    assert (pending === 1'b0) else begin
      n_err++;
      $error("FAIL %s pending got %b exp 0", tag, pending);
    end
    n_vec++;
    assert (frame_done === 1'b0) else begin
      n_err++;
      $error("FAIL %s frame_done got %b exp 0", tag, frame_done);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'h0;
    for (int k = 0; k < 4; k++)
      if ($urandom_range(0, 2) != 0) w[4*k +: 4] = 4'($urandom_range(0, 15));
    return w;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0;
    hex_mode  = 1'b0;
    blank_lz  = 1'b0;
    model_reset();
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: free-running scan of the all-zero display
    idx_loop: idle("scan", 2 * FRAME);

    // 2: mid-frame load, committed at the next wrap
    run_to_phase("load1234", 12);
    step("load1234", 1'b1, 16'h1234);
    idle("load1234", 2 * FRAME);

    // 3: leading-zero blanking with a decimal-invalid nibble, then hex
    blank_lz = 1'b1;
    step("lz_00A5", 1'b1, 16'h00A5);
    idle("lz_00A5", 2 * FRAME);
    hex_mode = 1'b1;
    idle("lz_00A5_hex", FRAME);
    hex_mode = 1'b0;

    // 4: all-zero shows a single 0, then 0070
    step("lz_0000", 1'b1, 16'h0000);
    idle("lz_0000", 2 * FRAME);
    step("lz_0070", 1'b1, 16'h0070);
    idle("lz_0070", 2 * FRAME);
    blank_lz = 1'b0;

    // 5: load exactly on the wrap edge
    hex_mode = 1'b1;
    run_to_phase("wrapload", 10);
    step("wrapload", 1'b1, 16'hAAAA);
    run_to_phase("wrapload", FRAME - 1);
    step("wrapload", 1'b1, 16'hBBBB);
    idle("wrapload", 2 * FRAME);

    // 6: asynchronous reset mid-frame with pending data
    run_to_phase("midreset", 4);
    step("midreset", 1'b1, 16'h9876);
    run_to_phase("midreset", 2 * DIV + 3);
    reset_n = 1'b0;
    #1;
    check_reset_state("midreset_async");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle("after_reset", FRAME + 4);

    // randomized traffic: loads, mode flips, all phases
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) hex_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) step("random", 1'b1, rand_word());
      else step("random", 1'b0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
